// File: rtl/multicycle_lookahead_adder.sv
// Wide unsigned adder that reuses one CHUNK-bit lookahead slice over WIDTH/CHUNK cycles,
// with valid/ready handshakes on both the operand and result sides.
module multicycle_lookahead_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int K  = WIDTH / CHUNK;
   localparam int CW = (K > 1) ? $clog2(K) : 1;
   localparam int NG = CHUNK / 4;
   localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_r_q, sum_r_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [CHUNK-1:0] slice_p, slice_g, slice_c, slice_sum;
   logic [NG:0]      grp_c;
   logic [WIDTH-1:0] sum_shift;

   // Carries are fully looked ahead inside each 4-bit group; groups chain through grp_c.
   always_comb begin
      logic [3:0] p4;
      logic [3:0] g4;
      logic       c0;
      slice_p  = a_sh_q[CHUNK-1:0] ^ b_sh_q[CHUNK-1:0];
      slice_g  = a_sh_q[CHUNK-1:0] & b_sh_q[CHUNK-1:0];
      slice_c  = '0;
      grp_c    = '0;
      grp_c[0] = carry_q;
      p4       = '0;
      g4       = '0;
      c0       = 1'b0;
      for (int j = 0; j < NG; j++) begin
         p4 = slice_p[4*j +: 4];
         g4 = slice_g[4*j +: 4];
         c0 = grp_c[j];
         slice_c[4*j]   = c0;
         slice_c[4*j+1] = g4[0] | (p4[0] & c0);
         slice_c[4*j+2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c0);
         slice_c[4*j+3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                        | (p4[2] & p4[1] & p4[0] & c0);
         grp_c[j+1]     = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                        | (p4[3] & p4[2] & p4[1] & g4[0]) | ((&p4) & c0);
      end
      slice_sum = slice_p ^ slice_c;
   end

   // New chunks enter at the MSB end so the sum lands in natural order after K shifts.
   if (K > 1) begin : g_multi
      assign sum_shift = {slice_sum, sum_r_q[WIDTH-1:CHUNK]};
   end else begin : g_single
      assign sum_shift = slice_sum;
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_r_d = sum_r_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_r_d = sum_shift;
            a_sh_d  = a_sh_q >> CHUNK;
            b_sh_d  = b_sh_q >> CHUNK;
            carry_d = grp_c[NG];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_r_q <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_r_q <= sum_r_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
   assign sum       = sum_r_q;
   assign cout      = carry_q;

endmodule

// File: doc/multicycle_lookahead_adder.md
# multicycle_lookahead_adder

Sequencer that performs a WIDTH-bit addition by time-multiplexing one CHUNK-bit lookahead carry slice over WIDTH/CHUNK clock cycles. The carry is registered between chunks. It is the area-reduced alternative to the fully unrolled wide lookahead adders: one 16-bit slice plus a shift/carry datapath replaces a 64-bit combinational adder. Operands enter and results leave through valid/ready handshakes, so the block can sit between pipeline stages of the arithmetic library.

## Interface
Parameters:
- WIDTH, 64, operand and sum width; must be an integer multiple of CHUNK
- CHUNK, 16, slice width added per cycle; multiple of 4, built from 4-bit lookahead carry groups

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  operand A, sampled on accept
- b  in  WIDTH  operand B, sampled on accept
- cin  in  1  carry-in, sampled on accept
- out_valid  out  1  sum/cout valid (high only in DONE)
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered result
- cout  out  1  registered carry-out of bit WIDTH-1
- busy  out  1  high in RUN or DONE

## Operation
- K = WIDTH/CHUNK (default 4). Internal chunk counter is ceil(log2(K)) bits, with a minimum of 1 bit.
- Registers: a_sh and b_sh (WIDTH each), carry (1), sum_r (WIDTH), cnt, state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, state<=RUN.
- RUN:
  - Slice adds a_sh[CHUNK-1:0] + b_sh[CHUNK-1:0] + carry using a 4-bit-group lookahead carry structure.
  - Each cycle: sum_r <= {slice_sum, sum_r[WIDTH-1:CHUNK]} (shift in from MSB side); a_sh and b_sh shift right by CHUNK; carry <= slice_cout; cnt <= cnt+1.
  - When cnt==K-1, the same edge sets state<=DONE. After K shifts, sum_r holds the full sum in natural bit order.
- DONE:
  - out_valid=1; sum=sum_r and cout=carry, held stable.
  - On out_ready: state<=IDLE.
- in_valid is ignored outside IDLE; the request is neither captured nor queued.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned. No overflow flag.
- K==1 is legal: RUN lasts exactly one cycle.

## Timing
- Reset (rst=1 at an edge), from any state including mid-RUN and DONE:
  - state<=IDLE; sum_r, a_sh, b_sh, carry, cnt <= 0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - An in-flight operation is discarded and no result is produced.
- rst has priority over every handshake in the same cycle.
- Accept happens at edge E0. out_valid is first high in the cycle after edge E0+K, giving a latency of K clocks (4 by default).
- Throughput: at most one result per K+2 cycles (accept cycle, K RUN cycles, at least one DONE cycle). in_ready returns high in the cycle after the output handshake.
- out_ready may be held high before DONE. DONE then lasts exactly one cycle.
- Backpressure: out_ready low holds DONE indefinitely, with sum and cout unchanged and in_ready=0.
- sum is only meaningful while out_valid=1. During RUN, sum_r carries partial data, and consumers must not sample it.
- No combinational path exists from any input to any output. in_ready, out_valid and busy are decoded from state only.

## Test plan
- Carry ripple across all chunks: a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h1, cin=0 -> after 4 cycles out_valid=1, sum=0, cout=1.
- Carry-in only: a=0, b=0, cin=1 -> sum=64'h1, cout=0. Then a=64'h0123_4567_89AB_CDEF, b=64'hFEDC_BA98_7654_3210, cin=0 -> sum=64'hFFFF_FFFF_FFFF_FFFF, cout=0.
- Backpressure and busy-drop:
  - Hold out_ready=0 for 6 cycles in DONE -> sum/cout stable, in_ready=0 throughout.
  - Pulse in_valid with a=5, b=7 during RUN and during DONE -> ignored; the next accepted result matches only the original operands.
- Reset mid-operation: assert rst for 1 cycle at cnt==2 -> next cycle in_ready=1, out_valid=0, sum=0, cout=0. A subsequent 3+4 request yields sum=7 after 4 cycles.
- Back-to-back: in_valid and out_ready held high continuously with 3 different operand sets -> a result every 6 cycles, each equal to the reference a+b+cin.
- Random regression with WIDTH=64/CHUNK=16 and WIDTH=32/CHUNK=32 (K=1): 10k random operands against a behavioural a+b+cin model -> zero mismatches, with latency always exactly K.
